// File: rtl/eig_stream_pkg.sv
// Shared types and helpers for the eigenvector result stream path.
package eig_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // A zero length means a full-size frame; oversize lengths clamp to the maximum.
  function automatic int eff_len(input int vec_len, input int max_size);
    if (vec_len == 0 || vec_len > max_size) begin
      return max_size;
    end
    return vec_len;
  endfunction

endpackage

// File: rtl/result_slot_buf.sv
// Two-slot ping-pong store for captured result vectors with their frame lengths.
// Owns the write/read pointers and the occupancy count that gates result_ready.
module result_slot_buf
  import eig_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_SIZE   = 32,
  parameter int LEN_W      = $clog2(MAX_SIZE + 1),
  parameter int IDX_W      = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] result_in [MAX_SIZE],
  input  logic                  result_valid,
  input  logic [LEN_W-1:0]      vec_len,
  input  logic                  slot_release,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  result_ready,
  output logic [1:0]            occupancy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LEN_W-1:0]      rd_len,
  output logic [DATA_WIDTH-1:0] alt_data0,
  output logic [LEN_W-1:0]      alt_len
);

  logic [DATA_WIDTH-1:0] slot [2][MAX_SIZE];
  logic [LEN_W-1:0]      len_q [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  capture;

  // With one slot occupied, wr_ptr already points at the free slot, so a
  // capture can never disturb the frame being streamed.
  assign result_ready = (occupancy != 2'd2);
  assign capture      = result_valid && result_ready;

  assign rd_data   = slot[rd_ptr][rd_idx];
  assign rd_len    = len_q[rd_ptr];
  assign alt_data0 = slot[~rd_ptr][0];
  assign alt_len   = len_q[~rd_ptr];

  // Vector storage: data only, no reset needed since occupancy qualifies it.
  always_ff @(posedge aclk) begin
    if (capture) begin
      for (int i = 0; i < MAX_SIZE; i++) begin
        slot[wr_ptr][i] <= result_in[i];
      end
    end
  end

  // Length latch, pointers and occupancy bookkeeping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
    end else begin
      if (capture) begin
        len_q[wr_ptr] <= LEN_W'(eff_len(int'(vec_len), MAX_SIZE));
        wr_ptr        <= ~wr_ptr;
      end
      if (slot_release) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({capture, slot_release})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/result_stream_tx.sv
// Serialises buffered eigenvector results onto an AXI-Stream master.
// Back-to-back frames stream without a bubble when the second slot is full.
module result_stream_tx
  import eig_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_SIZE   = 32,
  parameter int LEN_W      = $clog2(MAX_SIZE + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] result_in [MAX_SIZE],
  input  logic                  result_valid,
  input  logic [LEN_W-1:0]      vec_len,
  output logic                  result_ready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  tx_busy,
  output logic [7:0]            drop_count
);

  localparam int IDX_W = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;

  tx_state_t             state_q, state_d;
  logic                  tvalid_d, tlast_d;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic                  slot_release;
  logic [IDX_W-1:0]      rd_idx;
  logic [1:0]            occupancy;
  logic [DATA_WIDTH-1:0] rd_data, alt_data0;
  logic [LEN_W-1:0]      rd_len, alt_len;

  result_slot_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_SIZE   (MAX_SIZE),
    .LEN_W      (LEN_W),
    .IDX_W      (IDX_W)
  ) u_slots (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .result_in    (result_in),
    .result_valid (result_valid),
    .vec_len      (vec_len),
    .slot_release (slot_release),
    .rd_idx       (rd_idx),
    .result_ready (result_ready),
    .occupancy    (occupancy),
    .rd_data      (rd_data),
    .rd_len       (rd_len),
    .alt_data0    (alt_data0),
    .alt_len      (alt_len)
  );

  assign tx_busy = (occupancy != 2'd0) || m_axis_tvalid;

  // Next-state and next-beat selection; outputs hold unless a transfer moves them on.
  always_comb begin
    state_d      = state_q;
    tvalid_d     = m_axis_tvalid;
    tdata_d      = m_axis_tdata;
    tlast_d      = m_axis_tlast;
    idx_d        = idx_q;
    slot_release = 1'b0;
    rd_idx       = '0;
    case (state_q)
      IDLE: begin
        if (occupancy != 2'd0) begin
          tvalid_d = 1'b1;
          tdata_d  = rd_data;
          tlast_d  = (rd_len == LEN_W'(1));
          idx_d    = LEN_W'(1);
          state_d  = SEND;
        end
      end
      SEND: begin
        rd_idx = IDX_W'(idx_q);
        if (m_axis_tvalid && m_axis_tready) begin
          if (!m_axis_tlast) begin
            tdata_d = rd_data;
            tlast_d = (idx_q == rd_len - LEN_W'(1));
            idx_d   = idx_q + LEN_W'(1);
          end else begin
            slot_release = 1'b1;
            if (occupancy == 2'd2) begin
              tdata_d = alt_data0;
              tlast_d = (alt_len == LEN_W'(1));
              idx_d   = LEN_W'(1);
            end else begin
              tvalid_d = 1'b0;
              state_d  = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and stream output registers; reset drops tvalid immediately.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      idx_q         <= '0;
    end else begin
      state_q       <= state_d;
      m_axis_tvalid <= tvalid_d;
      m_axis_tdata  <= tdata_d;
      m_axis_tlast  <= tlast_d;
      idx_q         <= idx_d;
    end
  end

  // Saturating count of results refused because both slots were full.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      drop_count <= 8'd0;
    end else if (result_valid && !result_ready && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_result_stream_tx.sv
// Scoreboard bench for result_stream_tx: expected beats are queued when a
// result pulse is driven and compared as the stream hands them over.
module tb_result_stream_tx;

  localparam int DW = 32;
  localparam int MS = 32;
  localparam int LW = $clog2(MS + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] result_in [MS];
  logic          result_valid = 1'b0;
  logic [LW-1:0] vec_len = '0;
  logic          result_ready;
  logic          m_axis_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          tx_busy;
  logic [7:0]    drop_count;

  int    n_checks = 0;
  int    n_fail = 0;
  int    n_stalls = 0;
  int    cyc = 0;
  bit    mon_en = 1'b1;
  beat_t exp_q[$];
  int    acc_cyc[$];
  beat_t exp_b;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  result_stream_tx #(.DATA_WIDTH(DW), .MAX_SIZE(MS), .LEN_W(LW)) u_dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .result_in     (result_in),
    .result_valid  (result_valid),
    .vec_len       (vec_len),
    .result_ready  (result_ready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .tx_busy       (tx_busy),
    .drop_count    (drop_count)
  );

  always #5 aclk = ~aclk;

  // Monitor: sampled on the falling edge; a beat seen here transfers on the next rising edge.
  always @(negedge aclk) begin
    cyc++;
    if (mon_en) begin
      if (prev_stall) begin
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, required v=1 d=%h l=%b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
        acc_cyc.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got d=%h l=%b, required no beat", m_axis_tdata, m_axis_tlast);
        end else begin
          exp_b = exp_q.pop_front();
          if (m_axis_tdata !== exp_b.data || m_axis_tlast !== exp_b.last) begin
            n_fail++;
            $display("FAIL beat: got d=%h l=%b, required d=%h l=%b",
                     m_axis_tdata, m_axis_tlast, exp_b.data, exp_b.last);
          end
        end
      end
      prev_stall = (m_axis_tvalid === 1'b1) && (m_axis_tready === 1'b0);
      if (prev_stall) n_stalls++;
      prev_data = m_axis_tdata;
      prev_last = m_axis_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_frame(input int len, input logic [DW-1:0] base);
    int eff;
    beat_t b;
    eff = (len == 0 || len > MS) ? MS : len;
    for (int i = 0; i < eff; i++) begin
      b.data = base + DW'(i);
      b.last = (i == eff - 1);
      exp_q.push_back(b);
    end
  endtask

  // One-cycle result pulse; the capture (or drop) happens on the second rising edge.
  task automatic pulse(input int len, input logic [DW-1:0] base, input bit expect_cap);
    @(posedge aclk); #1;
    for (int i = 0; i < MS; i++) result_in[i] = base + DW'(i);
    vec_len = LW'(len);
    result_valid = 1'b1;
    if (expect_cap) push_frame(len, base);
    @(posedge aclk); #1;
    result_valid = 1'b0;
    for (int i = 0; i < MS; i++) result_in[i] = $urandom;
  endtask

  // mode 0: tready held high; mode 1: tready pattern 1,0,0,1 repeating.
  task automatic drain(input int budget, input int mode, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge aclk); #1;
      m_axis_tready = (mode == 1) ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (exp_q.size() == 0 && tx_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || m_axis_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stream: got v=%b d=%h l=%b, required 0 0 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    n_checks++;
    if (result_ready !== 1'b1 || tx_busy !== 1'b0 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_status: got rdy=%b busy=%b drops=%0d, required 1 0 0", result_ready, tx_busy, drop_count);
    end
    aresetn = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    acc_cyc.delete();
    m_axis_tready = 1'b1;
    pulse(4, 32'h100, 1'b1);
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_capture_cycle: got v=%b busy=%b, required v=0 busy=1", m_axis_tvalid, tx_busy);
    end
    @(posedge aclk); #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h100 || m_axis_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL single_first_beat: got v=%b d=%h l=%b, required v=1 d=00000100 l=0",
               m_axis_tvalid, m_axis_tdata, m_axis_tlast);
    end
    drain(50, 0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_drain: got timeout, required drained"); end
    n_checks++;
    if (acc_cyc.size() != 4 || acc_cyc[3] - acc_cyc[0] != 3) begin
      n_fail++;
      $display("FAIL single_contiguous: got %0d beats, required 4 on consecutive cycles", acc_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int stalls0;
    acc_cyc.delete();
    stalls0 = n_stalls;
    pulse(4, 32'h100, 1'b1);
    drain(100, 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL bp_drain: got timeout, required drained"); end
    n_checks++;
    if (acc_cyc.size() != 4 || n_stalls == stalls0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d beats %0d stalls, required 4 beats and stalls>0",
               acc_cyc.size(), n_stalls - stalls0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    acc_cyc.delete();
    pulse(3, 32'h200, 1'b1);
    pulse(2, 32'h300, 1'b1);
    n_checks++;
    if (result_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full: got result_ready=%b, required 0", result_ready);
    end
    pulse(5, 32'h600, 1'b0);
    drain(60, 0, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_drain: got timeout, required drained"); end
    n_checks++;
    if (acc_cyc.size() != 5 || acc_cyc[4] - acc_cyc[0] != 4) begin
      n_fail++;
      $display("FAIL b2b_no_bubble: got %0d beats, required 5 on consecutive cycles", acc_cyc.size());
    end
    n_checks++;
    if (drop_count !== 8'd1) begin
      n_fail++;
      $display("FAIL b2b_drop_count: got %0d, required 1", drop_count);
    end
  endtask

  task automatic test_len_edges();
    bit ok;
    int lens [3] = '{0, MS + 5, 1};
    int want [3] = '{MS, MS, 1};
    for (int k = 0; k < 3; k++) begin
      acc_cyc.delete();
      pulse(lens[k], 32'h1000 * (k + 1), 1'b1);
      drain(200, 0, ok);
      n_checks++;
      if (!ok || acc_cyc.size() != want[k]) begin
        n_fail++;
        $display("FAIL len_edge_%0d: got %0d beats ok=%b, required %0d beats",
                 lens[k], acc_cyc.size(), ok, want[k]);
      end
    end
  endtask

  task automatic test_release_capture();
    bit ok;
    acc_cyc.delete();
    pulse(2, 32'h700, 1'b1);
    @(posedge aclk);
    pulse(3, 32'h800, 1'b1);
    n_checks++;
    if (u_dut.u_slots.occupancy !== 2'd1 || m_axis_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL relcap_edge: got occ=%0d v=%b, required occ=1 v=0",
               u_dut.u_slots.occupancy, m_axis_tvalid);
    end
    @(posedge aclk); #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h800) begin
      n_fail++;
      $display("FAIL relcap_restart: got v=%b d=%h, required v=1 d=00000800", m_axis_tvalid, m_axis_tdata);
    end
    drain(60, 0, ok);
    n_checks++;
    if (!ok || acc_cyc.size() != 5 || acc_cyc[1] - acc_cyc[0] != 1 || acc_cyc[2] - acc_cyc[1] != 2) begin
      n_fail++;
      $display("FAIL relcap_gap: got %0d beats ok=%b, required 5 beats with one idle cycle between frames",
               acc_cyc.size(), ok);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    acc_cyc.delete();
    pulse(8, 32'h900, 1'b1);
    for (int c = 0; c < 20 && acc_cyc.size() < 2; c++) begin
      @(posedge aclk); #1;
    end
    n_checks++;
    if (acc_cyc.size() < 2) begin
      n_fail++;
      $display("FAIL midrst_reach: got %0d beats, required 2", acc_cyc.size());
    end
    #2;
    mon_en = 1'b0;
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || result_ready !== 1'b1 || drop_count !== 8'd0 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_async: got v=%b rdy=%b drops=%0d busy=%b, required 0 1 0 0",
               m_axis_tvalid, result_ready, drop_count, tx_busy);
    end
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    mon_en = 1'b1;
    acc_cyc.delete();
    pulse(3, 32'hA00, 1'b1);
    drain(60, 0, ok);
    n_checks++;
    if (!ok || acc_cyc.size() != 3) begin
      n_fail++;
      $display("FAIL midrst_clean: got %0d beats ok=%b, required 3 beats", acc_cyc.size(), ok);
    end
  endtask

  initial begin
    for (int i = 0; i < MS; i++) result_in[i] = '0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_len_edges();
    test_release_capture();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d beats outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
